muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage of the f_11 processor, directly downstream of the register file. It takes the two registered read operands (`regReadDataA`/`regReadDataB`) plus funct3 and destination register, computes over multiple cycles, and returns a 32-bit result and write address. The execute stage forwards these to the register file write port (`regWriteData`/`regAddrWrite`/`regWrite`).

---
 rtl/muldiv_unit_if.sv | 45 ++++
 rtl/muldiv_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the execute-stage issue logic and the
// iterative RV32M multiply/divide unit.
//
// Signals:
//   start   issue request, sampled by the unit only while it is idle
//   funct3  operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   opA     rs1 operand
//   opB     rs2 operand
//   rdIn    destination register address
//   flush   pipeline-flush abort
//   busy    unit is working on an accepted request
//   done    one-cycle completion pulse; result/rdOut valid while high
//   result  computed value
//   rdOut   destination address of the completed operation
//
// Modports:
//   master  issuing stage (drives requests)
//   slave   muldiv_unit (drives responses)
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [4:0]      rdIn;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rdOut;

  modport master (
    output start, funct3, opA, opB, rdIn, flush,
    input  busy, done, result, rdOut
  );

  modport slave (
    input  start, funct3, opA, opB, rdIn, flush,
    output busy, done, result, rdOut
  );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the execute stage. Operands are
// captured when a request is accepted; the unit then runs a radix-2
// shift-add multiply or a restoring divide on operand magnitudes (one bit
// per cycle, 32 iterations) and applies the sign fix-up on the way out.
// Divide-by-zero and signed overflow are answered without iterating.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave: start/funct3/opA/opB/rdIn/flush in,
//          busy/done/result/rdOut out (all outputs registered)
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies use one 33x33 signed
//                       product and complete with divide-special-case
//                       latency; divides are unaffected.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [5:0] ITERATIONS = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Conditional two's-complement negate used for all sign fix-ups.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                             input logic             n);
    neg_if = n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v,
                                                    input logic               n);
    neg_if_wide = n ? -v : v;
  endfunction

  // Control state
  state_t          state_q, state_d;
  logic [5:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;

  // Operation captured at acceptance
  logic [2:0]      f3_p0;
  logic [4:0]      rd_p0;
  logic            neg_p0;
  logic            special_p0;
  logic [XLEN-1:0] spec_res_p0;
  logic [XLEN-1:0] acc_hi_p0;
  logic [XLEN-1:0] acc_lo_p0;
  logic [XLEN-1:0] opb_p0;

  // Request decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            s_a;
  logic            s_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special_in;
  logic            mul_skip;
  logic            neg_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] spec_res_in;
  logic            accept;
  logic            finish;

  always_comb begin
    is_div   = bus.funct3[2];
    a_signed = is_div ? ~bus.funct3[0]
                      : (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU);
    b_signed = is_div ? ~bus.funct3[0] : (bus.funct3 == F3_MULH);
    s_a      = a_signed & bus.opA[XLEN-1];
    s_b      = b_signed & bus.opB[XLEN-1];
    mag_a    = neg_if(bus.opA, s_a);
    mag_b    = neg_if(bus.opB, s_b);

    div_zero = is_div && (bus.opB == '0);
    div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
               (bus.opA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.opB == '1);
    special_in = div_zero || div_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU.
    spec_res_in = '0;
    if (div_zero) begin
      spec_res_in = bus.funct3[1] ? bus.opA : '1;
    end else if (div_ovf) begin
      spec_res_in = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Remainder takes the dividend's sign; quotient and product take the XOR.
    neg_in = (is_div && bus.funct3[1]) ? s_a : (s_a ^ s_b);

`ifdef MULDIV_FAST_MUL_EN
    mul_skip = ~is_div;
`else
    mul_skip = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.start) begin
          accept  = 1'b1;
          state_d = (special_in || mul_skip) ? FIN : CALC;
        end
      end
      CALC: begin
        // The last iteration is the one that takes the counter to zero.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd1) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    finish = (state_q == FIN) && !bus.flush;
  end

  // Iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_fits;
  logic            unused_div_bit;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, opb_p0} : '0);
    div_shift = {acc_hi_p0, acc_lo_p0[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_p0};
    div_fits  = ~div_diff[XLEN+1];
  end

  // A successful trial subtraction always leaves a value below the divisor,
  // so bit XLEN of the difference is never needed.
  assign unused_div_bit = div_diff[XLEN];

`ifdef MULDIV_FAST_MUL_EN
  logic                      sa_p0;
  logic                      sb_p0;
  logic signed [2*XLEN-1:0]  fast_a;
  logic signed [2*XLEN-1:0]  fast_b;
  logic signed [2*XLEN-1:0]  fast_prod;

  // Sign-extended 33-bit operands; the low 64 bits of the product are exact.
  always_comb begin
    fast_a    = $signed({{XLEN{sa_p0 & acc_lo_p0[XLEN-1]}}, acc_lo_p0});
    fast_b    = $signed({{XLEN{sb_p0 & opb_p0[XLEN-1]}}, opb_p0});
    fast_prod = fast_a * fast_b;
  end
`endif

  // Final result select and sign fix-up
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_result;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = fast_prod;
`else
    prod = neg_if_wide({acc_hi_p0, acc_lo_p0}, neg_p0);
`endif
    quo  = neg_if(acc_lo_p0, neg_p0);
    rem  = neg_if(acc_hi_p0, neg_p0);

    fin_result = '0;
    if (special_p0) begin
      fin_result = spec_res_p0;
    end else begin
      case (f3_p0)
        F3_MUL:                      fin_result = prod[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: fin_result = prod[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:             fin_result = quo;
        F3_REM, F3_REMU:             fin_result = rem;
        default:                     fin_result = '0;
      endcase
    end
  end

  // ---- control / output stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= accept || ((state_q != IDLE) && !bus.flush);
      done_q  <= finish;

      if (accept) begin
        cnt_q <= ITERATIONS;
      end else if (state_q == CALC) begin
        cnt_q <= bus.flush ? 6'd0 : (cnt_q - 6'd1);
      end

      if (finish) begin
        result_q <= fin_result;
        rd_q     <= rd_p0;
      end
    end
  end

  // ---- capture / iteration stage ----
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_p0       <= bus.funct3;
      rd_p0       <= bus.rdIn;
      neg_p0      <= neg_in;
      special_p0  <= special_in;
      spec_res_p0 <= spec_res_in;
      acc_hi_p0   <= '0;
      // The single-cycle multiplier wants raw operands, the iterative
      // paths want magnitudes.
      acc_lo_p0   <= mul_skip ? bus.opA : mag_a;
      opb_p0      <= mul_skip ? bus.opB : mag_b;
`ifdef MULDIV_FAST_MUL_EN
      sa_p0       <= a_signed;
      sb_p0       <= b_signed;
`endif
    end else if (state_q == CALC) begin
      if (f3_p0[2]) begin
        // Restoring divide: quotient bits shift into acc_lo from the right.
        acc_hi_p0 <= div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        acc_lo_p0 <= {acc_lo_p0[XLEN-2:0], div_fits};
      end else begin
        // Shift-add multiply: {acc_hi, acc_lo} shifts right one bit per step.
        acc_hi_p0 <= mul_sum[XLEN:1];
        acc_lo_p0 <= {mul_sum[0], acc_lo_p0[XLEN-1:1]};
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rdOut  = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request sampled at the next rising edge (E0) and report the
  // number of edges until done is seen (-1 if it never arrives).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        output int lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.opA    = a;
    bus.opB    = b;
    bus.rdIn   = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
    checks++; if (bus.rdOut !== 5'd0) begin errors++; $display("FAIL reset_rdout got=%0d exp=0", bus.rdOut); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat;
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, lat);
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", bus.result); end
    checks++; if (bus.rdOut !== 5'd5) begin errors++; $display("FAIL mul_rdout got=%0d exp=5", bus.rdOut); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_with_done got=%b exp=1", bus.busy); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_after got=%b exp=0", bus.busy); end
    checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_held got=%h exp=ffffffeb", bus.result); end
  endtask

  task automatic test_mulh();
    logic [2:0]  f3  [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] exp [3] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(f3[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'd10 + 5'(i), lat);
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mulh_latency f3=%0d got=%0d exp=%0d", f3[i], lat, MUL_LAT); end
      checks++; if (bus.result !== exp[i]) begin errors++; $display("FAIL mulh_result f3=%0d got=%h exp=%h", f3[i], bus.result, exp[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 5'd20 + 5'(i), lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency f3=%0d got=%0d exp=33", f3[i], lat); end
      checks++; if (bus.result !== exp[i]) begin errors++; $display("FAIL div_result f3=%0d got=%h exp=%h", f3[i], bus.result, exp[i]); end
      checks++; if (bus.rdOut !== 5'd20 + 5'(i)) begin errors++; $display("FAIL div_rdout f3=%0d got=%0d exp=%0d", f3[i], bus.rdOut, 20 + i); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3  [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 5'd0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency case=%0d got=%0d exp=1", i, lat); end
      checks++; if (bus.result !== exp[i]) begin errors++; $display("FAIL special_result case=%0d got=%h exp=%h", i, bus.result, exp[i]); end
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    run_op(3'd5, 32'd100, 32'd7, 5'd9, lat);
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL flush_setup_result got=%h exp=0000000e", bus.result); end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.opA    = 32'd1000;
    bus.opB    = 32'd3;
    bus.rdIn   = 5'd17;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_e0 got=%b exp=1", bus.busy); end
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    seen = 0;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_e11 got=%b exp=0", bus.busy); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done) seen++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL flush_result_kept got=%h exp=0000000e", bus.result); end
    checks++; if (bus.rdOut !== 5'd9) begin errors++; $display("FAIL flush_rdout_kept got=%0d exp=9", bus.rdOut); end
  endtask

  task automatic test_start_ignored();
    int dones;
    int first;
    logic [31:0] res;
    logic [4:0]  rd;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.opA    = 32'd100;
    bus.opB    = 32'd7;
    bus.rdIn   = 5'd12;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    first = -1;
    res   = '0;
    rd    = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'd4;
        bus.opA    = 32'd5;
        bus.opB    = 32'd0;
        bus.rdIn   = 5'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (first < 0) begin
          first = k;
          res   = bus.result;
          rd    = bus.rdOut;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (first !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", first); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL ignore_result got=%h exp=0000000e", res); end
    checks++; if (rd !== 5'd12) begin errors++; $display("FAIL ignore_rdout got=%0d exp=12", rd); end
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.opA    = 32'd3;
    bus.opB    = 32'd5;
    bus.rdIn   = 5'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL areset_result got=%h exp=00000000", bus.result); end
    checks++; if (bus.rdOut !== 5'd0) begin errors++; $display("FAIL areset_rdout got=%0d exp=0", bus.rdOut); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, lat);
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL areset_after_latency got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL areset_after_result got=%h exp=ffffffeb", bus.result); end
    checks++; if (bus.rdOut !== 5'd5) begin errors++; $display("FAIL areset_after_rdout got=%0d exp=5", bus.rdOut); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(3'd5, 32'd100, 32'd7, 5'd1, lat);
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL b2b_first_result got=%h exp=0000000e", bus.result); end
    // Next request lands on the edge where done falls.
    run_op(3'd7, 32'd100, 32'd7, 5'd2, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
    checks++; if (bus.result !== 32'd2) begin errors++; $display("FAIL b2b_second_result got=%h exp=00000002", bus.result); end
    checks++; if (bus.rdOut !== 5'd2) begin errors++; $display("FAIL b2b_second_rdout got=%0d exp=2", bus.rdOut); end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.opA    = '0;
    bus.opB    = '0;
    bus.rdIn   = '0;
    bus.flush  = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
